// File: rtl/nibble_packer_pkg.sv
// Shared types for the nibble packer.
// FSM state encoding and nibble width.
package nibble_packer_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_packer.sv
// Packs an MSB-first nibble stream into an N-bit word
// and strobes word_valid for one cycle per completed word.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int N = 64,
  localparam int NIBS = N / NIB_W,
  localparam int CW = $clog2(NIBS)
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          clr,
  input  logic          nib_valid,
  input  logic [3:0]    nib_in,
  output logic          nib_ready,
  output logic [N-1:0]  word_out,
  output logic          word_valid,
  output logic [CW-1:0] nib_count,
  output logic          busy
);

  if ((N % NIB_W) != 0 || N < 8) begin : g_bad_n
    $error("nibble_packer: N must be a multiple of 4 and >= 8");
  end

  localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt_nx;
  logic          accept;
  logic          load;

  // Only the low NIBS-1 nibbles matter; the top one is
  // shifted straight out into word_out on completion.
  logic [N-5:0]  sh;
  logic [N-1:0]  sh_cat;

  assign sh_cat    = {sh, nib_in};
  assign nib_ready = (state != DONE);
  assign busy      = (nib_count != '0);
  assign accept    = nib_valid && nib_ready && !clr;

  always_comb begin
    state_nx = state;
    cnt_nx   = nib_count;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr) begin
          cnt_nx = '0;
        end else if (accept) begin
          cnt_nx   = CW'(1);
          state_nx = FILL;
        end
      end
      FILL: begin
        if (clr) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (accept) begin
          if (nib_count == LAST) begin
            cnt_nx   = '0;
            load     = 1'b1;
            state_nx = DONE;
          end else begin
            cnt_nx = nib_count + CW'(1);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state      <= IDLE;
      nib_count  <= '0;
      sh         <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      nib_count  <= cnt_nx;
      word_valid <= load;
      if (accept) begin
        sh <= sh_cat[N-5:0];
      end
      if (load) begin
        word_out <= sh_cat;
      end
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: directed table at N=16, corner
// sequences, and a random run against an arithmetic model.
module tb_nibble_packer;

  logic CLK = 1'b0;
  logic R = 1'b1;

  logic        c16, v16, r16, wv16, b16;
  logic [3:0]  n16;
  logic [15:0] w16;
  logic [1:0]  k16;

  logic        c64, v64, r64, wv64, b64;
  logic [3:0]  n64;
  logic [63:0] w64;
  logic [3:0]  k64;

  int npass = 0;
  int ntotal = 0;

  always #5 CLK = ~CLK;

  nibble_packer #(.N(16)) dut16 (
    .CLK(CLK), .R(R), .clr(c16), .nib_valid(v16),
    .nib_in(n16), .nib_ready(r16), .word_out(w16),
    .word_valid(wv16), .nib_count(k16), .busy(b16)
  );

  nibble_packer #(.N(64)) dut64 (
    .CLK(CLK), .R(R), .clr(c64), .nib_valid(v64),
    .nib_in(n64), .nib_ready(r64), .word_out(w64),
    .word_valid(wv64), .nib_count(k64), .busy(b64)
  );

  typedef struct {
    logic        v;
    logic        c;
    logic [3:0]  n;
    logic        rdy;
    int          cnt;
    logic        wv;
    logic [15:0] w;
  } vec_t;

  vec_t tv[31];

  function automatic vec_t mk(logic v, logic c, logic [3:0] n,
                              logic rdy, int cnt, logic wv,
                              logic [15:0] w);
    vec_t t;
    t.v = v; t.c = c; t.n = n;
    t.rdy = rdy; t.cnt = cnt; t.wv = wv; t.w = w;
    return t;
  endfunction

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk16(string tag, logic rdy, int cnt,
                       logic wv, logic [15:0] w);
    check({tag, ".ready16"}, 64'(r16), 64'(rdy));
    check({tag, ".count16"}, 64'(k16), 64'(cnt));
    check({tag, ".busy16"}, 64'(b16), 64'(cnt != 0));
    check({tag, ".valid16"}, 64'(wv16), 64'(wv));
    check({tag, ".word16"}, 64'(w16), 64'(w));
  endtask

  task automatic feed16(logic [3:0] n);
    v16 = 1'b1; c16 = 1'b0; n16 = n;
    tick();
  endtask

  // Arithmetic reference model, one slot per instance.
  int          nibs[2] = '{4, 16};
  int          mcnt[2];
  logic [63:0] macc[2];
  logic [63:0] mword[2];
  logic        mdone[2];
  logic        mwv[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; macc[i] = '0; mword[i] = '0;
      mdone[i] = 1'b0; mwv[i] = 1'b0;
    end
  endtask

  function automatic logic model_step(int i, logic v, logic c,
                                      logic [3:0] n);
    logic acc_now;
    acc_now = !mdone[i] && v && !c;
    mwv[i] = 1'b0;
    if (mdone[i]) begin
      mdone[i] = 1'b0;
    end else if (c) begin
      mcnt[i] = 0; macc[i] = '0;
    end else if (v) begin
      macc[i] = macc[i] * 16 + 64'(n);
      mcnt[i] = mcnt[i] + 1;
      if (mcnt[i] == nibs[i]) begin
        mword[i] = macc[i];
        macc[i] = '0; mcnt[i] = 0;
        mdone[i] = 1'b1; mwv[i] = 1'b1;
      end
    end
    return acc_now;
  endfunction

  initial begin
    int strobes;
    logic a16, a64;
    c16 = 0; v16 = 0; n16 = 0;
    c64 = 0; v64 = 0; n64 = 0;

    tv[0]  = mk(1, 0, 4'h1, 1, 1, 0, 16'h0000);
    tv[1]  = mk(1, 0, 4'h2, 1, 2, 0, 16'h0000);
    tv[2]  = mk(1, 0, 4'h3, 1, 3, 0, 16'h0000);
    tv[3]  = mk(1, 0, 4'h4, 0, 0, 1, 16'h1234);
    tv[4]  = mk(0, 0, 4'h0, 1, 0, 0, 16'h1234);
    tv[5]  = mk(1, 0, 4'hA, 1, 1, 0, 16'h1234);
    tv[6]  = mk(1, 0, 4'hB, 1, 2, 0, 16'h1234);
    tv[7]  = mk(1, 0, 4'hC, 1, 3, 0, 16'h1234);
    tv[8]  = mk(1, 0, 4'hD, 0, 0, 1, 16'hABCD);
    tv[9]  = mk(1, 0, 4'h0, 1, 0, 0, 16'hABCD);
    tv[10] = mk(1, 0, 4'h0, 1, 1, 0, 16'hABCD);
    tv[11] = mk(1, 0, 4'hF, 1, 2, 0, 16'hABCD);
    tv[12] = mk(1, 0, 4'h0, 1, 3, 0, 16'hABCD);
    tv[13] = mk(1, 0, 4'hF, 0, 0, 1, 16'h0F0F);
    tv[14] = mk(1, 0, 4'hE, 1, 0, 0, 16'h0F0F);
    tv[15] = mk(1, 0, 4'hE, 1, 1, 0, 16'h0F0F);
    tv[16] = mk(0, 1, 4'h0, 1, 0, 0, 16'h0F0F);
    tv[17] = mk(1, 0, 4'h5, 1, 1, 0, 16'h0F0F);
    tv[18] = mk(1, 0, 4'h6, 1, 2, 0, 16'h0F0F);
    tv[19] = mk(1, 1, 4'h7, 1, 0, 0, 16'h0F0F);
    tv[20] = mk(0, 0, 4'h0, 1, 0, 0, 16'h0F0F);
    tv[21] = mk(1, 0, 4'h9, 1, 1, 0, 16'h0F0F);
    tv[22] = mk(1, 0, 4'h8, 1, 2, 0, 16'h0F0F);
    tv[23] = mk(1, 0, 4'h7, 1, 3, 0, 16'h0F0F);
    tv[24] = mk(1, 0, 4'h6, 0, 0, 1, 16'h9876);
    tv[25] = mk(0, 0, 4'h0, 1, 0, 0, 16'h9876);
    tv[26] = mk(1, 0, 4'h1, 1, 1, 0, 16'h9876);
    tv[27] = mk(1, 0, 4'h1, 1, 2, 0, 16'h9876);
    tv[28] = mk(1, 0, 4'h1, 1, 3, 0, 16'h9876);
    tv[29] = mk(1, 0, 4'h1, 0, 0, 1, 16'h1111);
    tv[30] = mk(0, 1, 4'h0, 1, 0, 0, 16'h1111);

    tick();
    tick();
    chk16("reset", 1'b1, 0, 1'b0, 16'h0);
    check("reset.word64", w64, 64'h0);
    check("reset.count64", 64'(k64), 64'h0);
    check("reset.valid64", 64'(wv64), 64'h0);
    check("reset.ready64", 64'(r64), 64'h1);
    R = 1'b0;

    for (int i = 0; i < 31; i++) begin
      v16 = tv[i].v; c16 = tv[i].c; n16 = tv[i].n;
      tick();
      chk16($sformatf("vec%0d", i), tv[i].rdy, tv[i].cnt,
            tv[i].wv, tv[i].w);
    end

    // Asynchronous reset in the middle of a partial word
    feed16(4'h2);
    feed16(4'h3);
    feed16(4'h4);
    v16 = 1'b0;
    check("prereset.count16", 64'(k16), 64'd3);
    #3 R = 1'b1;
    #1;
    chk16("async_rst", 1'b1, 0, 1'b0, 16'h0);
    #1 R = 1'b0;
    feed16(4'hC);
    feed16(4'hA);
    feed16(4'hF);
    feed16(4'hE);
    chk16("after_rst", 1'b0, 0, 1'b1, 16'hCAFE);
    v16 = 1'b0;
    tick();
    chk16("after_rst_idle", 1'b1, 0, 1'b0, 16'hCAFE);

    // N=64: nibbles 0..F with random valid gaps
    strobes = 0;
    for (int i = 0; i < 16; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        v64 = 1'b0; n64 = 4'(i);
        tick();
        check("gap.count64", 64'(k64), 64'(i));
        if (wv64) strobes++;
      end
      v64 = 1'b1; n64 = 4'(i);
      tick();
      check("fill.count64", 64'(k64), 64'((i + 1) % 16));
      if (wv64) strobes++;
    end
    check("word64", w64, 64'h0123456789ABCDEF);
    v64 = 1'b0;
    tick();
    if (wv64) strobes++;
    check("strobes64", 64'(strobes), 64'd1);
    check("idle.ready64", 64'(r64), 64'h1);

    // Random run against the model
    R = 1'b1;
    tick();
    R = 1'b0;
    model_reset();
    a16 = 1'b1; a64 = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      c16 = ($urandom_range(0, 19) == 0);
      c64 = ($urandom_range(0, 39) == 0);
      if (a16 || !v16) begin
        v16 = ($urandom_range(0, 3) != 0);
        n16 = 4'($urandom);
      end
      if (a64 || !v64) begin
        v64 = ($urandom_range(0, 3) != 0);
        n64 = 4'($urandom);
      end
      a16 = model_step(0, v16, c16, n16);
      a64 = model_step(1, v64, c64, n64);
      tick();
      if (t % 3 == 0) begin
        chk16("rnd16", !mdone[0], mcnt[0], mwv[0],
              mword[0][15:0]);
        check("rnd.count64", 64'(k64), 64'(mcnt[1]));
        check("rnd.ready64", 64'(r64), 64'(!mdone[1]));
        check("rnd.busy64", 64'(b64), 64'(mcnt[1] != 0));
        check("rnd.valid64", 64'(wv64), 64'(mwv[1]));
        check("rnd.word64", w64, mword[1]);
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Assembles an N-bit word from a stream of 4-bit nibbles delivered MSB-first, e.g. from switch or keypad entry on the FPGA board. It is the writer for the board's enabled N-bit register. Once a full word is collected it presents the word and pulses a one-cycle load strobe that drives that register's data and enable inputs directly. It also exposes fill progress for display and supports a synchronous abort.

## Interface

- N, default 64: word width in bits; must be a multiple of 4 and at least 8.
- CLK  in  1  rising-edge clock.
- R  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous abort of a partial word.
- nib_valid  in  1  nib_in is valid this cycle.
- nib_in  in  4  nibble; the first nibble accepted becomes word_out[N-1:N-4].
- nib_ready  out  1  block can accept a nibble this cycle.
- word_out  out  N  last completed word; held until the next completion.
- word_valid  out  1  one-cycle strobe, word_out newly updated; connects to the register enable.
- nib_count  out  $clog2(N/4)  nibbles accepted into the current partial word.
- busy  out  1  partial word in progress (nib_count != 0).

## Operation

- NIBS = N/4. A nibble is accepted on a rising edge where nib_valid && nib_ready && !clr.
- Internal shift register sh[N-1:0] is updated as sh <= {sh[N-5:0], nib_in} on each accept.
- States:
  - IDLE: nib_ready=1, count 0. Accept → FILL with count=1. When NIBS=1 this is not allowed, since N≥8.
  - FILL: nib_ready=1. Accept with count < NIBS-1 → count+1.
  - FILL, accept with count == NIBS-1: word_out <= {sh[N-5:0], nib_in} at that same edge, count → 0, → DONE.
  - DONE: nib_ready=0, word_valid=1, lasts exactly one cycle, then → IDLE.
- clr in IDLE or FILL: count → 0, → IDLE, sh contents irrelevant, word_out unchanged, no strobe. clr wins over a simultaneous nib_valid.
- clr in DONE: ignored. The strobe still completes.
- nib_valid with nib_ready=0 (DONE): the nibble is not accepted. The source must hold it; nib_in may change only after an accept.
- Gaps in nib_valid are allowed anywhere in FILL. The state holds indefinitely.
- Reset, at any time including mid-word or during DONE: state IDLE, sh=0, word_out=0, word_valid=0, nib_count=0, busy=0, nib_ready=1 after R deasserts. No strobe is generated by reset.

## Timing

- All outputs are registered except nib_ready and busy, which are decoded from registered state only. No combinational path runs from any input to any output.
- Last nibble accepted at edge k: word_out is new and word_valid=1 from edge k to edge k+1. The downstream register captures word_out at edge k+1.
- Minimum period per word: NIBS+1 cycles (NIBS accepts plus 1 DONE cycle). For N=64 this is 17 cycles.
- First nibble of the next word can be accepted at edge k+2 (IDLE).
- nib_count wraps NIBS-1 → 0 only via completion or clr. It never reaches NIBS.

## Structure

- Shared package: state enum {IDLE, FILL, DONE} and constant NIB_W=4. Keep the parameter check (N % 4 == 0, N ≥ 8) as an elaboration-time assertion in the module.
- No sub-module. The shifter, counter and FSM are small enough to stay inline in one module of roughly 120–160 lines.

## Test plan

- N=16, reset, then nibbles 1,2,3,4 back-to-back → word_out=16'h1234, word_valid high exactly one cycle, 1 cycle after the 4th accept. nib_ready low that cycle.
- N=16, words 16'hABCD then 16'h0F0F streamed with nib_valid held high → second word's first nibble is accepted 2 edges after the first word's last accept. Two strobes; word_out holds 16'hABCD between them.
- N=16, nibbles 5,6 then clr with nib_valid=1 and nib_in=7 → count=0, busy=0, no strobe, word_out unchanged. Then 9,8,7,6 → 16'h9876.
- N=16, assert R asynchronously mid-clock after 3 accepts → all outputs 0 immediately. Next 4 nibbles form a fresh word.
- N=64, 16 nibbles 0..F with random nib_valid gaps → word_out=64'h0123456789ABCDEF, a single strobe, nib_count sequence 0..15 then 0.
- N=16, nib_valid asserted during DONE with nib_in=E → not accepted. Accepted next cycle as the first nibble: count=1.
